// File: rtl/hazard_stall_controller.sv
// Front-end stall/bubble/flush sequencing for the 5-stage MIPS pipeline.
// Covers load-use, branch-in-ID operand dependencies and HI/LO reads behind a busy MDU.
module hazard_stall_controller #(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic       ID_is_branch,
  input  logic       ID_is_mdu,
  input  logic       ID_reads_hilo,
  input  logic       branch_taken,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_RegWrite,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_MemRead,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       mdu_busy
);

  typedef enum logic {IDLE, DATA_STALL} state_t;

  state_t           r_state;
  logic [1:0]       r_rem;
  logic [CNT_W-1:0] r_mdu_cnt;

  logic       w_ex_match;
  logic       w_mem_match;
  logic [1:0] w_demand;
  logic       w_mdu_busy;
  logic       w_mdu_hazard;
  logic       w_stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign w_ex_match  = (ID_uses_rs && IF_ID_rs != 5'd0 && IF_ID_rs == ID_EX_rd) ||
                       (ID_uses_rt && IF_ID_rt != 5'd0 && IF_ID_rt == ID_EX_rd);
  assign w_mem_match = (ID_uses_rs && IF_ID_rs != 5'd0 && IF_ID_rs == EX_MEM_rd) ||
                       (ID_uses_rt && IF_ID_rt != 5'd0 && IF_ID_rt == EX_MEM_rd);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_demand = 2'd0;
    if (ID_is_branch && ID_EX_MemRead && w_ex_match) begin
      w_demand = 2'd2;
    end else if ((ID_EX_MemRead && w_ex_match) ||
                 (ID_is_branch && ID_EX_RegWrite && !ID_EX_MemRead && w_ex_match) ||
                 (ID_is_branch && EX_MEM_MemRead && w_mem_match)) begin
      w_demand = 2'd1;
    end
  end

  assign w_mdu_busy   = (r_mdu_cnt != '0);
  assign w_mdu_hazard = (ID_is_mdu || ID_reads_hilo) && w_mdu_busy;

  // Reset forces the combinational outputs to their reset values in the same cycle.
  assign w_stall = !reset && ((r_state == DATA_STALL) || (w_demand != 2'd0) || w_mdu_hazard);

  assign PC_Write     = !w_stall;
  assign IF_ID_Write  = !w_stall;
  assign ID_EX_Bubble = w_stall;
  assign IF_ID_Flush  = !reset && branch_taken && !w_stall;
  assign mdu_busy     = !reset && w_mdu_busy;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rem     <= 2'd0;
      r_mdu_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_demand == 2'd2) begin
            r_state <= DATA_STALL;
            r_rem   <= 2'd1;
          end
        end
        DATA_STALL: begin
          r_rem <= r_rem - 2'd1;
          if (r_rem <= 2'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A stalled MDU op does not issue, so it only reloads once it leaves ID.
      if (ID_is_mdu && !w_stall) begin
        r_mdu_cnt <= CNT_W'(MDU_LATENCY);
      end else if (w_mdu_busy) begin
        r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller: the driver queues hand-computed
// expectations, an independent monitor pops and compares them mid-cycle.
module tb_hazard_stall_controller;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt, br, mdu, hilo, taken;
    logic [4:0] exrd;
    logic       exrw, exmr;
    logic [4:0] memrd;
    logic       memmr;
  } in_t;

  typedef struct {
    string name;
    logic  pcw, ifw, bub, fl, busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rd = '0, EX_MEM_rd = '0;
  logic       ID_uses_rs = 0, ID_uses_rt = 0, ID_is_branch = 0, ID_is_mdu = 0;
  logic       ID_reads_hilo = 0, branch_taken = 0;
  logic       ID_EX_RegWrite = 0, ID_EX_MemRead = 0, EX_MEM_MemRead = 0;
  logic       PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, mdu_busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_is_branch(ID_is_branch), .ID_is_mdu(ID_is_mdu),
    .ID_reads_hilo(ID_reads_hilo), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .mdu_busy(mdu_busy)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".PC_Write"},     PC_Write,     e.pcw);
      check({e.name, ".IF_ID_Write"},  IF_ID_Write,  e.ifw);
      check({e.name, ".ID_EX_Bubble"}, ID_EX_Bubble, e.bub);
      check({e.name, ".IF_ID_Flush"},  IF_ID_Flush,  e.fl);
      check({e.name, ".mdu_busy"},     mdu_busy,     e.busy);
    end
  end

  function automatic in_t nop();
    in_t v;
    v = '{rst: 1'b0, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0, br: 1'b0, mdu: 1'b0,
          hilo: 1'b0, taken: 1'b0, exrd: 5'd0, exrw: 1'b0, exmr: 1'b0,
          memrd: 5'd0, memmr: 1'b0};
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
  task automatic step(input in_t v, input string name, input logic stall,
                      input logic fl, input logic busy);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = v.rst;
    IF_ID_rs       = v.rs;    IF_ID_rt       = v.rt;
    ID_uses_rs     = v.urs;   ID_uses_rt     = v.urt;
    ID_is_branch   = v.br;    ID_is_mdu      = v.mdu;
    ID_reads_hilo  = v.hilo;  branch_taken   = v.taken;
    ID_EX_rd       = v.exrd;  ID_EX_RegWrite = v.exrw;  ID_EX_MemRead = v.exmr;
    EX_MEM_rd      = v.memrd; EX_MEM_MemRead = v.memmr;
    e.name = name;
    e.pcw  = !stall;
    e.ifw  = !stall;
    e.bub  = stall;
    e.fl   = fl;
    e.busy = busy;
    sb.push_back(e);
  endtask

  initial begin
    in_t v;

    // Reset overrides a live load-use hazard and a taken branch.
    v = nop(); v.rst = 1; v.urs = 1; v.rs = 5; v.exrd = 5; v.exmr = 1; v.taken = 1;
    step(v, "rst_hazard", 0, 0, 0);
    v = nop(); v.rst = 1;
    step(v, "rst_plain", 0, 0, 0);
    step(nop(), "idle", 0, 0, 0);

    // lw $5 in EX, add reading rs=5: one bubble, then normal flow.
    v = nop(); v.urs = 1; v.rs = 5; v.exrd = 5; v.exrw = 1; v.exmr = 1;
    step(v, "loaduse", 1, 0, 0);
    v = nop(); v.urs = 1; v.rs = 5; v.memrd = 5; v.memmr = 1;
    step(v, "loaduse_rel", 0, 0, 0);
    v = nop(); v.urs = 1; v.rs = 0; v.exrd = 0; v.exrw = 1; v.exmr = 1;
    step(v, "loaduse_r0", 0, 0, 0);
    v = nop(); v.urs = 0; v.rs = 5; v.exrd = 5; v.exrw = 1; v.exmr = 1;
    step(v, "loaduse_nouse", 0, 0, 0);

    // lw $8 in EX, beq reading rt=8, taken held: two stalls, flush only in cycle 3.
    v = nop(); v.br = 1; v.urt = 1; v.rt = 8; v.exrd = 8; v.exrw = 1; v.exmr = 1; v.taken = 1;
    step(v, "lwbr_c1", 1, 0, 0);
    v = nop(); v.br = 1; v.urt = 1; v.rt = 8; v.taken = 1;
    step(v, "lwbr_c2", 1, 0, 0);
    step(v, "lwbr_c3", 0, 1, 0);

    // add $3 in EX feeding a branch: one stall; non-branch consumer forwards.
    v = nop(); v.br = 1; v.urs = 1; v.rs = 3; v.exrd = 3; v.exrw = 1;
    step(v, "alubr_c1", 1, 0, 0);
    v = nop(); v.br = 1; v.urs = 1; v.rs = 3; v.memrd = 3; v.taken = 1;
    step(v, "alubr_c2", 0, 1, 0);
    v = nop(); v.urs = 1; v.rs = 3; v.exrd = 3; v.exrw = 1;
    step(v, "alu_nobr", 0, 0, 0);

    // Branch behind a load in MEM: single stall.
    v = nop(); v.br = 1; v.urt = 1; v.rt = 9; v.memrd = 9; v.memmr = 1; v.taken = 1;
    step(v, "memld_br", 1, 0, 0);
    v = nop(); v.br = 1; v.urt = 1; v.rt = 9; v.taken = 1;
    step(v, "memld_br_rel", 0, 1, 0);

    // mult at t, mflo at t+1: stalls t+1..t+4, issues t+5.
    v = nop(); v.mdu = 1;
    step(v, "mult_t0", 0, 0, 0);
    v = nop(); v.hilo = 1;
    for (int i = 1; i <= 4; i++) step(v, $sformatf("mflo_t%0d", i), 1, 0, 1);
    step(v, "mflo_t5", 0, 0, 0);

    // Back-to-back mult/div: second waits, then reloads the counter.
    v = nop(); v.mdu = 1;
    step(v, "b2b_t0", 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(v, $sformatf("b2b_div_t%0d", i), 1, 0, 1);
    step(v, "b2b_div_t5", 0, 0, 0);
    for (int i = 6; i <= 9; i++) step(nop(), $sformatf("b2b_busy_t%0d", i), 0, 0, 1);
    step(nop(), "b2b_free_t10", 0, 0, 0);

    // Reset during DATA_STALL with the MDU busy: immediate abort, no residue.
    v = nop(); v.mdu = 1;
    step(v, "rs_mult", 0, 0, 0);
    v = nop(); v.br = 1; v.urs = 1; v.rs = 7; v.exrd = 7; v.exrw = 1; v.exmr = 1;
    step(v, "rs_lwbr", 1, 0, 1);
    v = nop(); v.rst = 1; v.hilo = 1; v.taken = 1;
    step(v, "rs_assert", 0, 0, 0);
    v = nop(); v.hilo = 1; v.taken = 1;
    step(v, "rs_release", 0, 1, 0);
    step(nop(), "rs_after", 0, 0, 0);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences front-end stalls, bubbles and flushes for the 5-stage MIPS pipeline.
- Detects data hazards that EX/ID forwarding cannot cover: load-use, branch-in-ID dependencies, and HI/LO dependencies on the multi-cycle multiply/divide unit (MDU).
- Drives PC/IF_ID write enables, the ID/EX bubble and the IF/ID flush.
- Sits beside the forwarding unit; when a stall is released, the forwarding unit's ID/EX paths must supply the operand.

Parameters:
- MDU_LATENCY, 4, cycles the MDU is busy after an MDU op leaves ID (1..15).
- CNT_W, 4, width of the MDU busy counter; must hold MDU_LATENCY.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- IF_ID_rs, IF_ID_rt  input  5 each  source registers of the instruction in ID.
- ID_uses_rs, ID_uses_rt  input  1 each  ID instruction actually reads rs / rt.
- ID_is_branch  input  1  ID holds a branch (compares resolved in ID).
- ID_is_mdu  input  1  ID holds mult/div.
- ID_reads_hilo  input  1  ID holds mfhi/mflo.
- branch_taken  input  1  ID branch/jump resolved taken this cycle.
- ID_EX_rd  input  5  destination register in EX.
- ID_EX_RegWrite, ID_EX_MemRead  input  1 each  EX control.
- EX_MEM_rd  input  5  destination register in MEM.
- EX_MEM_MemRead  input  1  MEM stage is a load.
- PC_Write  output  1  PC load enable.
- IF_ID_Write  output  1  IF/ID load enable.
- ID_EX_Bubble  output  1  zero ID/EX control (insert NOP).
- IF_ID_Flush  output  1  squash the IF/ID contents.
- mdu_busy  output  1  MDU counter nonzero.

Behaviour:
- Match rule: a source matches when its use bit is 1, the register != 0, and it equals the producer rd. Register 0 never causes a hazard.
- Hazard demand N, evaluated combinationally from current inputs, with the largest value winning:
  - Branch and ID_EX_MemRead match: N=2.
  - ID_EX_MemRead match on any instruction (load-use): N=1.
  - Branch and ID_EX_RegWrite match, with ID_EX_MemRead=0: N=1.
  - Branch and EX_MEM_MemRead match on EX_MEM_rd: N=1.
  - Otherwise N=0.
- MDU hazard: (ID_is_mdu or ID_reads_hilo) while mdu_busy=1.
- FSM states: IDLE, DATA_STALL. The remaining-stall counter rem is 2 bits.
  - IDLE: if N>0, stall this cycle. If N=2, load rem=1 and go to DATA_STALL; if N=1, stay in IDLE.
  - DATA_STALL: stall unconditionally, ignore N, decrement rem. Return to IDLE when rem reaches 0, i.e. after 1 cycle.
- Stall cycle outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
- A stall also occurs whenever the MDU hazard is true, in either state.
- Non-stall cycle outputs: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
- Flush: IF_ID_Flush = branch_taken and not stalling. branch_taken during a stall cycle is ignored, because the operands are unresolved; the branch re-resolves when released.
- MDU counter:
  - When ID_is_mdu=1 and the cycle is not stalled, load the counter with MDU_LATENCY on the next edge.
  - Otherwise decrement while nonzero; saturate at 0.
  - mdu_busy = (counter != 0).
  - An MDU op stalled behind a busy MDU issues in the first cycle the counter is 0 and reloads it then.
- Simultaneous data and MDU hazards: stall while either is active. DATA_STALL sequencing still completes on its own counter.
- Reset (synchronous, highest priority):
  - While reset=1, outputs take reset values: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, mdu_busy=0.
  - Next state is IDLE, rem=0, MDU counter=0.
  - Reset mid-stall or mid-MDU aborts immediately; no residual stall after deassertion.
- Latency: stall, bubble and flush outputs are combinational in the same cycle as the hazard. Only stall continuation and MDU busy are registered.

Test Plan:
- lw $5 in EX (ID_EX_MemRead=1, rd=5), add using rs=5 in ID -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, then normal flow; with rs=0 and rd=0 -> no stall.
- lw $8 in EX, beq reading rt=8 in ID -> exactly 2 stall cycles, including the DATA_STALL cycle when inputs change; branch_taken=1 held throughout -> IF_ID_Flush=1 only in cycle 3.
- add $3 in EX (RegWrite=1, MemRead=0), beq rs=3 -> 1 stall; same add with non-branch consumer -> 0 stalls.
- mult issues at cycle t, mflo in ID at t+1 -> stalls t+1..t+4 (MDU_LATENCY=4), mdu_busy high t+1..t+4, issues t+5; back-to-back mult/div -> second op waits, then counter reloads.
- Assert reset during the DATA_STALL cycle with mdu_busy=1 -> next cycle all outputs at reset values, no stall after release.
